// File: rtl/n25q_pkg.sv
// Shared constants for the N25Q serial flash model: opcodes, FSM states, ID bytes.
package n25q_pkg;

    localparam logic [7:0] OP_PP      = 8'h02;
    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_WRDI    = 8'h04;
    localparam logic [7:0] OP_RDSR    = 8'h05;
    localparam logic [7:0] OP_WREN    = 8'h06;
    localparam logic [7:0] OP_SSE     = 8'h20;
    localparam logic [7:0] OP_RDID    = 8'h9E;
    localparam logic [7:0] OP_WRNVCR  = 8'hB1;
    localparam logic [7:0] OP_RDNVCR  = 8'hB5;
    localparam logic [7:0] OP_EN4B    = 8'hB7;
    localparam logic [7:0] OP_BE      = 8'hC7;

    localparam logic [7:0]  ID_MFR     = 8'h20;
    localparam logic [7:0]  ID_TYPE    = 8'hBA;
    localparam logic [7:0]  ID_CAP     = 8'h19;
    localparam logic [15:0] NVCR_RST   = 16'hFFFF;
    localparam logic [31:0] VCC_MIN_MV = 32'd2700;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DATA_IN,
        ST_DATA_OUT,
        ST_IGNORE
    } state_t;

    function automatic logic [7:0] id_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return ID_MFR;
            3'd1:    return ID_TYPE;
            3'd2:    return ID_CAP;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/n25q_mem_array.sv
// Byte-wide flash array with one program port, 4 KB subsector fill and full-array fill.
module n25q_mem_array #(
    parameter int MEM_AW = 16
) (
    input  logic              C_,
    input  logic              i_we,
    input  logic [MEM_AW-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic              i_fill_sub,
    input  logic [MEM_AW-13:0] i_sub_idx,
    input  logic              i_fill_all,
    input  logic [MEM_AW-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    // Stored inverted in a 2-state array: power-up zeros read back as erased 8'hFF.
    bit [7:0] r_mem_n [2**MEM_AW];

    always_ff @(posedge C_) begin
        if (i_fill_all) begin
            for (int i = 0; i < 2**MEM_AW; i++) r_mem_n[MEM_AW'(i)] <= 8'h00;
        end else if (i_fill_sub) begin
            for (int i = 0; i < 4096; i++) r_mem_n[{i_sub_idx, 12'(i)}] <= 8'h00;
        end else if (i_we) begin
            r_mem_n[i_waddr] <= r_mem_n[i_waddr] | ~i_wdata;
        end
    end

    assign o_rdata = ~r_mem_n[i_raddr];

endmodule

// File: rtl/n25q_spi_flash.sv
// N25Q serial NOR flash model, SPI mode 0, single I/O, sampled on C_ rise, driven on C_ fall.
//   state       | meaning
//   ST_CMD      | shifting in the opcode
//   ST_ADDR     | shifting in 3 or 4 address bytes
//   ST_DATA_IN  | page-program or NVCR data bytes
//   ST_DATA_OUT | streaming a response byte per 8 clocks
//   ST_IGNORE   | command done or rejected, DQ1 idles high
module n25q_spi_flash
    import n25q_pkg::*;
#(
    parameter int MEM_AW    = 16,
    parameter int BE_CYCLES = 1023
) (
    input  logic        C_,
    input  logic        resetb,
    input  logic        S,
    input  logic        DQ0,
    output logic        DQ1,
    input  logic        HOLD_DQ3,
    input  logic        Vpp_W_DQ2,
    input  logic [31:0] Vcc
);

    localparam int BW = $clog2(BE_CYCLES + 1);
    localparam logic [BW-1:0]     BUSY_ONE = BW'(1);
    localparam logic [MEM_AW-1:0] ADDR_ONE = MEM_AW'(1);

    state_t            r_state;
    logic [2:0]        r_bitcnt;
    logic [2:0]        r_bytecnt;
    logic [6:0]        r_shift;
    logic [7:0]        r_opcode;
    logic [7:0]        r_out_byte;
    logic [MEM_AW-1:0] r_addr;
    logic              r_wel;
    logic              r_wip;
    logic              r_4b;
    logic              r_prog_pend;
    logic              r_dq1;
    logic [15:0]       r_nvcr;
    logic [7:0]        r_nvcr_lo;
    logic [BW-1:0]     r_busy;

    logic [7:0]        w_byte;
    logic              w_byte_end;
    logic [MEM_AW-1:0] w_addr_full;
    logic              w_last_addr;
    logic              w_cmd_ok;
    logic              w_wr_allow;
    logic [7:0]        w_status;
    logic              w_mem_we;
    logic              w_fill_sub;
    logic              w_fill_all;
    logic [MEM_AW-1:0] w_raddr;
    logic [7:0]        w_rdata;

    // While S is high the bit counter is held at 0, so no byte can complete.
    assign w_byte      = {r_shift, DQ0};
    assign w_byte_end  = HOLD_DQ3 && (r_bitcnt == 3'd7);
    assign w_addr_full = MEM_AW'({r_addr, w_byte});
    assign w_last_addr = (r_state == ST_ADDR) && (r_bytecnt == (r_4b ? 3'd3 : 3'd2));
    assign w_cmd_ok    = (Vcc >= VCC_MIN_MV) && (!r_wip || w_byte == OP_RDSR);
    assign w_wr_allow  = r_wel && Vpp_W_DQ2;
    assign w_status    = {1'b1, 5'b00000, r_wel, r_wip};

    assign w_mem_we   = w_byte_end && (r_state == ST_DATA_IN) && (r_opcode == OP_PP) && w_wr_allow;
    assign w_fill_sub = w_byte_end && w_last_addr && (r_opcode == OP_SSE) && w_wr_allow;
    assign w_fill_all = (r_busy == BUSY_ONE);
    assign w_raddr    = (r_state == ST_ADDR) ? w_addr_full : r_addr;

    always_ff @(posedge C_ or negedge resetb or posedge S) begin
        if (!resetb) begin
            r_state   <= ST_CMD;
            r_bitcnt  <= '0;
            r_bytecnt <= '0;
        end else if (S) begin
            r_state   <= ST_CMD;
            r_bitcnt  <= '0;
            r_bytecnt <= '0;
        end else if (HOLD_DQ3) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
                r_bytecnt <= (r_bytecnt == 3'd6) ? r_bytecnt : r_bytecnt + 3'd1;
                case (r_state)
                    ST_CMD: begin
                        r_bytecnt <= '0;
                        if (!w_cmd_ok) r_state <= ST_IGNORE;
                        else begin
                            case (w_byte)
                                OP_READ, OP_PP, OP_SSE:        r_state <= ST_ADDR;
                                OP_RDSR, OP_RDID, OP_RDNVCR:   r_state <= ST_DATA_OUT;
                                OP_WRNVCR:                     r_state <= ST_DATA_IN;
                                default:                       r_state <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        if (w_last_addr) begin
                            r_bytecnt <= '0;
                            case (r_opcode)
                                OP_READ: r_state <= ST_DATA_OUT;
                                OP_PP:   r_state <= ST_DATA_IN;
                                default: r_state <= ST_IGNORE;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge C_ or negedge resetb) begin
        if (!resetb) begin
            r_shift     <= '0;
            r_opcode    <= '0;
            r_out_byte  <= 8'hFF;
            r_addr      <= '0;
            r_wel       <= 1'b0;
            r_wip       <= 1'b0;
            r_4b        <= 1'b0;
            r_prog_pend <= 1'b0;
            r_nvcr      <= NVCR_RST;
            r_nvcr_lo   <= '0;
            r_busy      <= '0;
        end else begin
            if (r_busy != '0) begin
                r_busy <= r_busy - BUSY_ONE;
                if (r_busy == BUSY_ONE) begin
                    r_wip <= 1'b0;
                    r_wel <= 1'b0;
                end
            end
            // Program left DATA_IN, so S has risen since the last committed byte.
            if (r_prog_pend && r_state != ST_DATA_IN) begin
                r_wel       <= 1'b0;
                r_prog_pend <= 1'b0;
            end
            if (HOLD_DQ3) r_shift <= w_byte[6:0];
            if (w_byte_end) begin
                case (r_state)
                    ST_CMD: begin
                        r_opcode <= w_byte;
                        r_addr   <= '0;
                        if (w_cmd_ok) begin
                            case (w_byte)
                                OP_WREN:   r_wel <= 1'b1;
                                OP_WRDI:   r_wel <= 1'b0;
                                OP_EN4B:   r_4b  <= 1'b1;
                                OP_BE: begin
                                    if (w_wr_allow) begin
                                        r_wip  <= 1'b1;
                                        r_busy <= BW'(BE_CYCLES);
                                    end
                                end
                                OP_RDSR:   r_out_byte <= w_status;
                                OP_RDID:   r_out_byte <= id_byte(3'd0);
                                OP_RDNVCR: r_out_byte <= r_nvcr[7:0];
                                default: ;
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        r_addr <= w_addr_full;
                        if (w_last_addr && r_opcode == OP_READ) begin
                            r_out_byte <= w_rdata;
                            r_addr     <= w_addr_full + ADDR_ONE;
                        end
                        if (w_fill_sub) r_wel <= 1'b0;
                    end
                    ST_DATA_IN: begin
                        if (r_opcode == OP_PP) begin
                            r_addr <= {r_addr[MEM_AW-1:8], r_addr[7:0] + 8'd1};
                            if (w_wr_allow) r_prog_pend <= 1'b1;
                        end else if (r_opcode == OP_WRNVCR) begin
                            if (r_bytecnt == 3'd0) r_nvcr_lo <= w_byte;
                            else if (r_bytecnt == 3'd1) r_nvcr <= {w_byte, r_nvcr_lo};
                        end
                    end
                    ST_DATA_OUT: begin
                        case (r_opcode)
                            OP_READ: begin
                                r_out_byte <= w_rdata;
                                r_addr     <= r_addr + ADDR_ONE;
                            end
                            OP_RDSR:   r_out_byte <= w_status;
                            OP_RDID:   r_out_byte <= id_byte(r_bytecnt + 3'd1);
                            OP_RDNVCR: r_out_byte <= (r_bytecnt == 3'd0) ? r_nvcr[15:8] : 8'h00;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(negedge C_ or negedge resetb) begin
        if (!resetb) r_dq1 <= 1'b1;
        else if (HOLD_DQ3) r_dq1 <= (r_state == ST_DATA_OUT) ? r_out_byte[3'd7 - r_bitcnt] : 1'b1;
    end

    assign DQ1 = (S || !HOLD_DQ3) ? 1'bz : r_dq1;

    n25q_mem_array #(.MEM_AW(MEM_AW)) u_mem (
        .C_         (C_),
        .i_we       (w_mem_we),
        .i_waddr    (r_addr),
        .i_wdata    (w_byte),
        .i_fill_sub (w_fill_sub),
        .i_sub_idx  (w_addr_full[MEM_AW-1:12]),
        .i_fill_all (w_fill_all),
        .i_raddr    (w_raddr),
        .o_rdata    (w_rdata)
    );

endmodule

// File: tb/tb_n25q_spi_flash.sv
// Directed bench for n25q_spi_flash: expected response bytes are queued, then checked as they stream out.
module tb_n25q_spi_flash;

    logic        C_;
    logic        resetb;
    logic        S;
    logic        DQ0;
    wire         DQ1;
    logic        HOLD_DQ3;
    logic        Vpp_W_DQ2;
    logic [31:0] Vcc;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] wr_q  [$];
    logic       four_b = 1'b0;

    n25q_spi_flash #(.MEM_AW(16), .BE_CYCLES(1023)) dut (
        .C_        (C_),
        .resetb    (resetb),
        .S         (S),
        .DQ0       (DQ0),
        .DQ1       (DQ1),
        .HOLD_DQ3  (HOLD_DQ3),
        .Vpp_W_DQ2 (Vpp_W_DQ2),
        .Vcc       (Vcc)
    );

    task automatic clk_bit(input logic d, output logic q);
        DQ0 = d;
        #4;
        q = DQ1;
        #1 C_ = 1'b1;
        #5 C_ = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic q;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(tx[i], q);
            rx[i] = q;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] r;
        xfer(b, r);
    endtask

    task automatic cs_on();
        S = 1'b0;
        #5;
    endtask

    task automatic cs_off();
        #5 S = 1'b1;
        #5;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            #5 C_ = 1'b1;
            #5 C_ = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        logic [7:0] rx;
        logic [7:0] e;
        while (exp_q.size() != 0) begin
            xfer(8'h00, rx);
            e = exp_q.pop_front();
            total++;
            assert (rx === e) else begin
                bad++;
                $error("FAIL %s observed=%02h expected=%02h", tag, rx, e);
            end
        end
    endtask

    task automatic cmd1(input logic [7:0] op);
        cs_on();
        send(op);
        cs_off();
    endtask

    task automatic send_addr(input logic [31:0] a);
        if (four_b) send(a[31:24]);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    task automatic rdsr(input logic [7:0] e, input int n, input string tag);
        for (int i = 0; i < n; i++) exp_q.push_back(e);
        cs_on();
        send(8'h05);
        drain(tag);
        cs_off();
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        cs_on();
        send(8'h03);
        send_addr(a);
        drain(tag);
        cs_off();
    endtask

    task automatic pp(input logic [31:0] a);
        cmd1(8'h06);
        cs_on();
        send(8'h02);
        send_addr(a);
        while (wr_q.size() != 0) send(wr_q.pop_front());
        cs_off();
    endtask

    initial begin
        logic q;
        C_ = 1'b0; S = 1'b1; DQ0 = 1'b0; HOLD_DQ3 = 1'b1; Vpp_W_DQ2 = 1'b1; Vcc = 32'd3300;
        resetb = 1'b0;
        #20 resetb = 1'b1;
        #10;

        exp_q.push_back(8'h20); exp_q.push_back(8'hBA); exp_q.push_back(8'h19);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        cs_on(); send(8'h9E); drain("rdid"); cs_off();

        rdsr(8'h80, 1, "sr_reset");
        cmd1(8'h06);
        rdsr(8'h82, 2, "sr_wren");
        cmd1(8'h04);
        rdsr(8'h80, 1, "sr_wrdi");

        wr_q.push_back(8'hAA); wr_q.push_back(8'h55);
        pp(32'h10);
        exp_q.push_back(8'hAA); exp_q.push_back(8'h55); exp_q.push_back(8'hFF);
        rd(32'h10, "read_pp");
        rdsr(8'h80, 1, "sr_after_pp");

        wr_q.push_back(8'h0F);
        pp(32'h10);
        exp_q.push_back(8'h0A);
        rd(32'h10, "pp_and");

        wr_q.push_back(8'h0F); wr_q.push_back(8'hF0);
        pp(32'h1FF);
        exp_q.push_back(8'h0F);
        rd(32'h1FF, "page_wrap_hi");
        exp_q.push_back(8'hF0);
        rd(32'h100, "page_wrap_lo");

        cs_on(); send(8'hB1); send(8'h34); send(8'h12); cs_off();
        exp_q.push_back(8'h34); exp_q.push_back(8'h12); exp_q.push_back(8'h00);
        cs_on(); send(8'hB5); drain("nvcr"); cs_off();

        cmd1(8'hB7);
        four_b = 1'b1;
        exp_q.push_back(8'h0A); exp_q.push_back(8'h55);
        rd(32'h10, "read_4b");

        cmd1(8'h06);
        cmd1(8'hC7);
        rdsr(8'h83, 2, "sr_busy");
        cmd1(8'h04);
        rdsr(8'h83, 1, "wip_ignore");
        idle(1100);
        rdsr(8'h80, 1, "sr_be_done");
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        rd(32'h0, "be_read0");
        exp_q.push_back(8'hFF);
        rd(32'h10, "be_read10");

        wr_q.push_back(8'h12);
        pp(32'h0);
        exp_q.push_back(8'h12);
        rd(32'h0, "prog4b");
        exp_q.push_back(8'hFF); exp_q.push_back(8'h12);
        rd(32'h0000FFFF, "read_wrap");

        Vpp_W_DQ2 = 1'b0;
        cmd1(8'h06);
        cs_on(); send(8'h20); send_addr(32'h0); cs_off();
        Vpp_W_DQ2 = 1'b1;
        exp_q.push_back(8'h12);
        rd(32'h0, "wp_sse");

        cmd1(8'h06);
        cs_on(); send(8'h20); send_addr(32'h0); cs_off();
        exp_q.push_back(8'hFF);
        rd(32'h0, "sse");
        rdsr(8'h80, 1, "sr_after_sse");

        cs_on();
        for (int i = 0; i < 4; i++) clk_bit(1'b0, q);
        cs_off();
        rdsr(8'h80, 1, "abort_wren");

        Vcc = 32'd2500;
        cmd1(8'h06);
        Vcc = 32'd3300;
        rdsr(8'h80, 1, "vcc_low");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
